// File: rtl/data_sram_bridge_if.sv
// -----------------------------------------------------------------------------
// data_sram_bridge_if
//   Bundles the two sides of the bridge: the core's single-cycle data SRAM
//   port (cpu_*) and the split-transaction SRAM-like bus (mem_*).
//
//   modport master : the bridge view. It receives the core request and the
//                    bus handshakes, and drives the bus request and the
//                    core response.
//   modport slave  : the environment view (core + memory side), mirror of
//                    master.
//
//   cpu_en/cpu_wen/cpu_addr/cpu_wdata : core request (wen = 0 means read)
//   cpu_rdata/cpu_stall               : core response
//   mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata : address phase
//   mem_addr_ok/mem_data_ok/mem_rdata : bus handshakes and read return
// -----------------------------------------------------------------------------
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cpu_en;
    logic [3:0]        cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
//   Turns the core's single-cycle data SRAM access into one split-transaction
//   access on an SRAM-like bus (address handshake, then data handshake).
//   One access is in flight at a time; the core is stalled until it finishes,
//   and read data is returned from a buffer in the single DONE cycle.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     bus        --   data_sram_bridge_if.master (cpu_* and mem_* signals)
//     stall_cnt  out  saturating count of cycles with cpu_stall high
// -----------------------------------------------------------------------------
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    data_sram_bridge_if.master bus,
    output logic [31:0]        stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic              wr_q,        wr_d;
    logic [1:0]        size_q,      size_d;
    logic [3:0]        wstrb_q,     wstrb_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic              stall;
    logic              req;

    // Transfer size from byte enables. Only the contiguous naturally aligned
    // patterns map to byte/half; anything else (including a read, wen = 0)
    // is issued as a full word.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            4'b0011, 4'b1100:                   sz = 2'd1;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        req         = 1'b0;

        case (state_q)
            IDLE: begin
                stall = bus.cpu_en;
                if (bus.cpu_en) begin
                    // The bus encoding is computed once here so that every
                    // mem_* output is a plain register during the address
                    // phase and cannot change before mem_addr_ok.
                    wr_d    = |bus.cpu_wen;
                    size_d  = size_of(bus.cpu_wen);
                    wstrb_d = bus.cpu_wen;
                    addr_d  = (|bus.cpu_wen) ? bus.cpu_addr
                                             : {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = bus.cpu_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                stall = 1'b1;
                req   = 1'b1;
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        rdata_d = bus.mem_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                stall = 1'b1;
                if (bus.mem_data_ok) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                // cpu_en here still belongs to the access being completed.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            wstrb_q     <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // mem_req is decoded from the state so it drops the instant reset hits.
    assign bus.mem_req   = req;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_stall = stall;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Size table: byte enables, address, expected size, expected address.
    logic [3:0]  tbl_wen  [7] = '{4'b1100, 4'b0101, 4'b0011, 4'b1111, 4'b0001, 4'b1000, 4'b1010};
    logic [31:0] tbl_addr [7] = '{32'h3002, 32'h3000, 32'h3000, 32'h3004, 32'h3001, 32'h3003, 32'h3008};
    logic [1:0]  tbl_size [7] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2};

    task automatic clear_inputs();
        bus.cpu_en      = 1'b0;
        bus.cpu_wen     = 4'd0;
        bus.cpu_addr    = 32'd0;
        bus.cpu_wdata   = 32'd0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0)     begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.mem_req); end
        n_checks++; if (bus.mem_wr !== 1'b0)      begin n_fail++; $display("FAIL rst_wr got %b exp 0", bus.mem_wr); end
        n_checks++; if (bus.mem_size !== 2'd0)    begin n_fail++; $display("FAIL rst_size got %0d exp 0", bus.mem_size); end
        n_checks++; if (bus.mem_wstrb !== 4'd0)   begin n_fail++; $display("FAIL rst_wstrb got %b exp 0000", bus.mem_wstrb); end
        n_checks++; if (bus.mem_addr !== 32'd0)   begin n_fail++; $display("FAIL rst_addr got %h exp 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'd0)  begin n_fail++; $display("FAIL rst_wdata got %h exp 0", bus.mem_wdata); end
        n_checks++; if (bus.cpu_rdata !== 32'd0)  begin n_fail++; $display("FAIL rst_rdata got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (bus.cpu_stall !== 1'b0)   begin n_fail++; $display("FAIL rst_stall got %b exp 0", bus.cpu_stall); end
        n_checks++; if (stall_cnt !== 32'd0)      begin n_fail++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        // Handshakes in IDLE must not start anything.
        @(negedge clk);
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h1234_5678;
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (bus.mem_req !== 1'b0)     begin n_fail++; $display("FAIL idle_ok_req got %b exp 0", bus.mem_req); end
        n_checks++; if (bus.cpu_rdata !== 32'd0)  begin n_fail++; $display("FAIL idle_ok_rdata got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (stall_cnt !== 32'd0)      begin n_fail++; $display("FAIL idle_ok_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_word_read();
        int stalls = 0;
        do_reset();
        @(negedge clk);
        bus.cpu_en = 1'b1; bus.cpu_wen = 4'd0; bus.cpu_addr = 32'h1003;
        #1; stalls += int'(bus.cpu_stall);
        n_checks++; if (bus.cpu_stall !== 1'b1)   begin n_fail++; $display("FAIL rd_idle_stall got %b exp 1", bus.cpu_stall); end
        @(negedge clk);
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1; stalls += int'(bus.cpu_stall);
        n_checks++; if (bus.mem_req !== 1'b1)     begin n_fail++; $display("FAIL rd_req got %b exp 1", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'h1000) begin n_fail++; $display("FAIL rd_addr got %h exp 00001000", bus.mem_addr); end
        n_checks++; if (bus.mem_size !== 2'd2)    begin n_fail++; $display("FAIL rd_size got %0d exp 2", bus.mem_size); end
        n_checks++; if (bus.mem_wr !== 1'b0)      begin n_fail++; $display("FAIL rd_wr got %b exp 0", bus.mem_wr); end
        n_checks++; if (bus.mem_wstrb !== 4'd0)   begin n_fail++; $display("FAIL rd_wstrb got %b exp 0000", bus.mem_wstrb); end
        @(negedge clk);
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
        #1; stalls += int'(bus.cpu_stall);
        n_checks++; if (bus.cpu_stall !== 1'b0)   begin n_fail++; $display("FAIL rd_done_stall got %b exp 0", bus.cpu_stall); end
        n_checks++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef", bus.cpu_rdata); end
        n_checks++; if (stalls != 2)              begin n_fail++; $display("FAIL rd_stall_cycles got %0d exp 2", stalls); end
        n_checks++; if (stall_cnt !== 32'd2)      begin n_fail++; $display("FAIL rd_stall_cnt got %0d exp 2", stall_cnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_byte_write_wait();
        int stalls = 0;
        int reqs   = 0;
        do_reset();
        @(negedge clk);
        bus.cpu_en = 1'b1; bus.cpu_wen = 4'b0100; bus.cpu_addr = 32'h2006; bus.cpu_wdata = 32'h00AB_0000;
        #1; stalls += int'(bus.cpu_stall);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_addr_ok = (i == 2);
            #1; stalls += int'(bus.cpu_stall); reqs += int'(bus.mem_req);
            n_checks++; if (bus.mem_size !== 2'd0)      begin n_fail++; $display("FAIL bw_size[%0d] got %0d exp 0", i, bus.mem_size); end
            n_checks++; if (bus.mem_addr !== 32'h2006)  begin n_fail++; $display("FAIL bw_addr[%0d] got %h exp 00002006", i, bus.mem_addr); end
            n_checks++; if (bus.mem_wstrb !== 4'b0100)  begin n_fail++; $display("FAIL bw_wstrb[%0d] got %b exp 0100", i, bus.mem_wstrb); end
            n_checks++; if (bus.mem_wr !== 1'b1)        begin n_fail++; $display("FAIL bw_wr[%0d] got %b exp 1", i, bus.mem_wr); end
            n_checks++; if (bus.mem_wdata !== 32'h00AB_0000) begin n_fail++; $display("FAIL bw_wdata[%0d] got %h exp 00ab0000", i, bus.mem_wdata); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = (i == 1);
            #1; stalls += int'(bus.cpu_stall); reqs += int'(bus.mem_req);
            n_checks++; if (bus.mem_req !== 1'b0)       begin n_fail++; $display("FAIL bw_data_req[%0d] got %b exp 0", i, bus.mem_req); end
        end
        @(negedge clk);
        bus.mem_data_ok = 1'b0;
        #1; stalls += int'(bus.cpu_stall); reqs += int'(bus.mem_req);
        n_checks++; if (bus.cpu_stall !== 1'b0)   begin n_fail++; $display("FAIL bw_done_stall got %b exp 0", bus.cpu_stall); end
        n_checks++; if (reqs != 3)                begin n_fail++; $display("FAIL bw_req_cycles got %0d exp 3", reqs); end
        n_checks++; if (stalls != 6)              begin n_fail++; $display("FAIL bw_stall_cycles got %0d exp 6", stalls); end
        n_checks++; if (stall_cnt !== 32'd6)      begin n_fail++; $display("FAIL bw_stall_cnt got %0d exp 6", stall_cnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_sizes();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.cpu_en = 1'b1; bus.cpu_wen = tbl_wen[k]; bus.cpu_addr = tbl_addr[k]; bus.cpu_wdata = 32'hA5A5_0000 + k;
            @(negedge clk);
            bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
            #1;
            n_checks++; if (bus.mem_size !== tbl_size[k]) begin n_fail++; $display("FAIL sz_size wen=%b got %0d exp %0d", tbl_wen[k], bus.mem_size, tbl_size[k]); end
            n_checks++; if (bus.mem_wr !== 1'b1)           begin n_fail++; $display("FAIL sz_wr wen=%b got %b exp 1", tbl_wen[k], bus.mem_wr); end
            n_checks++; if (bus.mem_wstrb !== tbl_wen[k])  begin n_fail++; $display("FAIL sz_wstrb wen=%b got %b", tbl_wen[k], bus.mem_wstrb); end
            n_checks++; if (bus.mem_addr !== tbl_addr[k])  begin n_fail++; $display("FAIL sz_addr wen=%b got %h exp %h", tbl_wen[k], bus.mem_addr, tbl_addr[k]); end
            @(negedge clk);
            bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
            @(negedge clk);
            clear_inputs();
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int reqs   = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
            case (c)
                0: begin bus.cpu_en = 1'b1; bus.cpu_wen = 4'd0; bus.cpu_addr = 32'h40; end
                1: begin bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1111_2222; end
                2: begin bus.cpu_wen = 4'b1111; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'hCAFE_F00D; end
                4: begin bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h55AA_55AA; end
                6: bus.cpu_en = 1'b0;
                default: ;
            endcase
            #1; stalls += int'(bus.cpu_stall); reqs += int'(bus.mem_req);
            if (c == 2) begin
                n_checks++; if (bus.cpu_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_rdata got %h exp 11112222", bus.cpu_rdata); end
                n_checks++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done1_stall got %b exp 0", bus.cpu_stall); end
            end
            if (c == 2 || c == 3) begin
                n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_req c%0d got %b exp 0", c, bus.mem_req); end
            end
            if (c == 4) begin
                n_checks++; if (bus.mem_addr !== 32'h44 || bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_req addr %h wr %b exp 00000044 1", bus.mem_addr, bus.mem_wr); end
            end
        end
        n_checks++; if (reqs != 2)            begin n_fail++; $display("FAIL b2b_req_cycles got %0d exp 2", reqs); end
        n_checks++; if (stalls != 4)          begin n_fail++; $display("FAIL b2b_stall_cycles got %0d exp 4", stalls); end
        n_checks++; if (stall_cnt !== 32'd4)  begin n_fail++; $display("FAIL b2b_stall_cnt got %0d exp 4", stall_cnt); end
    endtask

    task automatic test_async_reset();
        // Starts from the previous test's state: buffer and counter are non-zero.
        @(negedge clk);
        bus.cpu_en = 1'b1; bus.cpu_wen = 4'd0; bus.cpu_addr = 32'h80;
        @(negedge clk);
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        bus.mem_addr_ok = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL ar_in_data req %b stall %b exp 0 1", bus.mem_req, bus.cpu_stall); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (dut.state_q !== 2'd0)     begin n_fail++; $display("FAIL ar_state got %0d exp 0", dut.state_q); end
        n_checks++; if (bus.cpu_stall !== 1'b1)   begin n_fail++; $display("FAIL ar_stall_en got %b exp 1", bus.cpu_stall); end
        n_checks++; if (bus.mem_req !== 1'b0)     begin n_fail++; $display("FAIL ar_req got %b exp 0", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'd0 || bus.mem_size !== 2'd0 || bus.mem_wr !== 1'b0 || bus.mem_wstrb !== 4'd0 || bus.mem_wdata !== 32'd0)
            begin n_fail++; $display("FAIL ar_mem_outs addr %h size %0d wr %b wstrb %b wdata %h exp all 0", bus.mem_addr, bus.mem_size, bus.mem_wr, bus.mem_wstrb, bus.mem_wdata); end
        n_checks++; if (bus.cpu_rdata !== 32'd0)  begin n_fail++; $display("FAIL ar_rdata got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (stall_cnt !== 32'd0)      begin n_fail++; $display("FAIL ar_stall_cnt got %0d exp 0", stall_cnt); end
        bus.cpu_en = 1'b0;
        #1;
        n_checks++; if (bus.cpu_stall !== 1'b0)   begin n_fail++; $display("FAIL ar_stall got %b exp 0", bus.cpu_stall); end
        @(negedge clk);
        rst = 1'b0;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
        #1;
        n_checks++; if (dut.state_q !== 2'd0)     begin n_fail++; $display("FAIL ar_late_state got %0d exp 0", dut.state_q); end
        n_checks++; if (bus.cpu_rdata !== 32'd0)  begin n_fail++; $display("FAIL ar_late_rdata got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (stall_cnt !== 32'd0)      begin n_fail++; $display("FAIL ar_late_stall_cnt got %0d exp 0", stall_cnt); end
        n_checks++; if (bus.mem_req !== 1'b0)     begin n_fail++; $display("FAIL ar_late_req got %b exp 0", bus.mem_req); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_word_read();
        test_byte_write_wait();
        test_sizes();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
